// File: rtl/cpu16_pkg.sv
// ============================================================================
// Module      : cpu16_pkg
// Description : Shared CPU16 widths and the block-copy engine state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu16_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_WRITE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mem_copy_addr_gen.sv
// ============================================================================
// Module      : mem_copy_addr_gen
// Description : Base/index/remaining counters producing source and destination
//               word addresses plus a last-word flag for the copy engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_copy_addr_gen
    import cpu16_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [15:0]       len_i,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [15:0]       idx_q;
    logic [15:0]       remaining_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q       <= '0;
            dst_q       <= '0;
            idx_q       <= '0;
            remaining_q <= '0;
        end else if (load_i) begin
            src_q       <= src_i;
            dst_q       <= dst_i;
            idx_q       <= '0;
            remaining_q <= len_i;
        end else if (step_i) begin
            idx_q       <= idx_q + 16'd1;
            remaining_q <= remaining_q - 16'd1;
        end
    end

    // Additions are truncated to ADDR_W, giving the silent wrap at the top of memory.
    assign src_addr_o = src_q + ADDR_W'(idx_q);
    assign dst_addr_o = dst_q + ADDR_W'(idx_q);
    assign last_o     = (remaining_q == 16'd1);

endmodule

`default_nettype wire

// File: rtl/mem_copy_engine.sv
// ============================================================================
// Module      : mem_copy_engine
// Description : Block-copy initiator on the CPU16 data-memory port; copies one
//               word every two cycles (READ then WRITE) in ascending order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_copy_engine
    import cpu16_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [15:0]       length_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] address_o,
    output logic [DATA_W-1:0] write_data_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    input  logic [DATA_W-1:0] read_data_i
);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] data_q;
    logic              accept;
    logic              last_word;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;

    assign accept = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    mem_copy_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (accept),
        .step_i     (state_q == ST_WRITE),
        .src_i      (src_addr_i),
        .dst_i      (dst_addr_i),
        .len_i      (length_i),
        .src_addr_o (src_addr),
        .dst_addr_o (dst_addr),
        .last_o     (last_word)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (!start_i)                state_d = ST_IDLE;
                else if (length_i == 16'd0)  state_d = ST_DONE;
                else                         state_d = ST_READ;
            end
            ST_READ:  state_d = abort_i ? ST_IDLE : ST_WRITE;
            ST_WRITE: begin
                if (abort_i)        state_d = ST_IDLE;
                else if (last_word) state_d = ST_DONE;
                else                state_d = ST_READ;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (state_q == ST_READ) begin
            data_q <= read_data_i;
        end
    end

    // Memory strobes depend only on registered state, so an async reset drops them at once.
    always_comb begin
        busy_o       = 1'b0;
        done_o       = 1'b0;
        address_o    = '0;
        write_data_o = '0;
        mem_write_o  = 1'b0;
        mem_read_o   = 1'b0;
        case (state_q)
            ST_READ: begin
                busy_o     = 1'b1;
                address_o  = src_addr;
                mem_read_o = 1'b1;
            end
            ST_WRITE: begin
                busy_o       = 1'b1;
                address_o    = dst_addr;
                write_data_o = data_q;
                mem_write_o  = 1'b1;
            end
            ST_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
// ============================================================================
// Module      : tb_mem_copy_engine
// Description : Self-checking bench for mem_copy_engine with a word-addressed
//               data memory and a cycle-schedule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] src = '0;
    logic [15:0] dst = '0;
    logic [15:0] len = '0;
    logic        busy, done, mem_write, mem_read;
    logic [15:0] address, wdata, read_data;

    logic [15:0] mem  [0:65535];
    logic [15:0] mmem [0:65535];

    int tests = 0;
    int fails = 0;

    // Model: cycle number since the accepting edge (0 = idle) and latched job.
    int          m_n = 0;
    int          m_len = 0;
    logic [15:0] m_src = '0;
    logic [15:0] m_dst = '0;

    always #5 clk = ~clk;

    mem_copy_engine #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .abort_i      (abort),
        .src_addr_i   (src),
        .dst_addr_i   (dst),
        .length_i     (len),
        .busy_o       (busy),
        .done_o       (done),
        .address_o    (address),
        .write_data_o (wdata),
        .mem_write_o  (mem_write),
        .mem_read_o   (mem_read),
        .read_data_i  (read_data)
    );

    assign read_data = mem_read ? mem[address] : 16'h0000;

    always @(posedge clk) begin
        if (mem_write) mem[address] = wdata;
    end

    always @(posedge clk or posedge rst) begin
        int k;
        if (rst) begin
            m_n = 0;
        end else if (m_n == 0 || m_n == 2*m_len + 1) begin
            if (start) begin
                m_src = src; m_dst = dst; m_len = int'(len); m_n = 1;
            end else begin
                m_n = 0;
            end
        end else begin
            k = (m_n - 1) / 2;
            if (m_n % 2 == 0) mmem[m_dst + 16'(k)] = mmem[m_src + 16'(k)];
            if (abort) m_n = 0;
            else       m_n = m_n + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        logic e_busy, e_done, e_rd, e_wr;
        logic [15:0] e_addr, e_wd;
        int k;
        @(negedge clk);
        e_busy = (m_n >= 1) && (m_n <= 2*m_len);
        e_done = (m_n != 0) && (m_n == 2*m_len + 1);
        e_rd   = e_busy && (m_n % 2 == 1);
        e_wr   = e_busy && (m_n % 2 == 0);
        k      = (m_n - 1) / 2;
        e_addr = e_rd ? m_src + 16'(k) : (e_wr ? m_dst + 16'(k) : 16'h0000);
        e_wd   = e_wr ? mmem[m_src + 16'(k)] : 16'h0000;
        check("cycle", {28'h0, busy, done, mem_read, mem_write, address, wdata},
                       {28'h0, e_busy, e_done, e_rd, e_wr, e_addr, e_wd});
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] v);
        mem[a]  = v;
        mmem[a] = v;
    endtask

    task automatic go(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        start = 1'b1; src = s; dst = d; len = l;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]  = 16'(i) ^ 16'h5A5A;
            mmem[i] = 16'(i) ^ 16'h5A5A;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {28'h0, busy, done, mem_read, mem_write, address, wdata}, 64'h0);
        rst = 1'b0;
        tick();

        // Basic 3-word copy with hand-timed Busy/Done.
        poke(16'd10, 16'd7); poke(16'd11, 16'd8); poke(16'd12, 16'd9);
        go(16'd10, 16'd40, 16'd3);
        for (int n = 1; n <= 8; n++) begin
            tick();
            start = 1'b0;
            check($sformatf("busy_c%0d", n), {63'h0, busy}, {63'h0, (n <= 6)});
            check($sformatf("done_c%0d", n), {63'h0, done}, {63'h0, (n == 7)});
        end
        check("mem40", {48'h0, mem[40]}, 64'd7);
        check("mem41", {48'h0, mem[41]}, 64'd8);
        check("mem42", {48'h0, mem[42]}, 64'd9);

        // Zero length: immediate Done, no memory traffic.
        go(16'd5, 16'd6, 16'd0);
        tick();
        start = 1'b0;
        check("len0_c1", {60'h0, busy, done, mem_read, mem_write}, 64'b0100);
        tick();
        check("len0_c2", {63'h0, done}, 64'h0);
        check("len0_mem6", {48'h0, mem[6]}, 64'h5A5C);

        // Source address wraps past 0xFFFF.
        poke(16'hFFFF, 16'hAAAA); poke(16'h0000, 16'h5555);
        go(16'hFFFF, 16'h0100, 16'd2);
        for (int n = 1; n <= 6; n++) begin
            tick();
            start = 1'b0;
            if (n == 1) check("wrap_rd0", {47'h0, mem_read, address}, {47'h1, 16'hFFFF});
            if (n == 3) check("wrap_rd1", {47'h0, mem_read, address}, {47'h1, 16'h0000});
        end
        check("wrap_mem100", {48'h0, mem[16'h0100]}, 64'hAAAA);
        check("wrap_mem101", {48'h0, mem[16'h0101]}, 64'h5555);

        // Abort during the WRITE of word 2 (cycle 6): that write still lands.
        for (int i = 0; i < 4; i++) poke(16'(20 + i), 16'(16'h0101 * (i + 1)));
        go(16'd20, 16'd60, 16'd4);
        for (int n = 1; n <= 9; n++) begin
            tick();
            start = 1'b0;
            abort = (n == 6);
            if (n >= 7) check($sformatf("abort_idle_c%0d", n),
                              {60'h0, busy, done, mem_read, mem_write}, 64'h0);
        end
        check("abort_mem60", {48'h0, mem[60]}, 64'h0101);
        check("abort_mem61", {48'h0, mem[61]}, 64'h0202);
        check("abort_mem62", {48'h0, mem[62]}, 64'h0303);
        check("abort_mem63", {48'h0, mem[63]}, 64'h5A65);

        // Asynchronous reset in the middle of the first READ.
        go(16'd300, 16'd400, 16'd5);
        tick();
        start = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_rst", {28'h0, busy, done, mem_read, mem_write, address, wdata}, 64'h0);
        tick();
        rst = 1'b0;
        tick(); tick();
        check("rst_mem400", {48'h0, mem[400]}, 64'h5BCA);

        // Start while busy is ignored.
        go(16'd10, 16'd50, 16'd3);
        for (int n = 1; n <= 9; n++) begin
            tick();
            start = 1'b0;
            if (n == 3) go(16'd11, 16'd200, 16'd1);
        end
        check("busy_start_mem200", {48'h0, mem[200]}, 64'h5A92);
        check("busy_start_mem50", {48'h0, mem[50]}, 64'd7);
        check("busy_start_mem52", {48'h0, mem[52]}, 64'd9);

        // Back-to-back: second Start in the DONE cycle.
        go(16'd10, 16'd30, 16'd1);
        for (int n = 1; n <= 7; n++) begin
            tick();
            start = 1'b0;
            if (n == 3) begin
                check("b2b_done1", {63'h0, done}, 64'h1);
                go(16'd11, 16'd31, 16'd1);
            end
            if (n == 4) check("b2b_read", {47'h0, mem_read, address}, {47'h1, 16'd11});
            if (n == 6) check("b2b_done2", {63'h0, done}, 64'h1);
        end
        check("b2b_mem30", {48'h0, mem[30]}, 64'd7);
        check("b2b_mem31", {48'h0, mem[31]}, 64'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
